seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Parametrised, multi-cycle restoring integer divider for the ALU datapath.
- Replaces the fixed 32-bit combinational divider.
- Computes one quotient bit per clock, so the critical path is a single WIDTH-bit subtract instead of a WIDTH-deep chain.
- Adds signed mode, a start/done handshake, and divide-by-zero handling; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CW, $clog2(WIDTH+1), step-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock; the single clock for the block.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; latched with start.
- dividend  input  WIDTH  numerator; latched with start.
- divisor  input  WIDTH  denominator; latched with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag; updated together with done.

Behaviour:
- Reset values (reset high at a clk edge): state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; internal A/Q/counter cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1:
  - Latch neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]).
  - Latch neg_r = is_signed & dividend[MSB].
  - Latch magnitudes |dividend| and |divisor| (raw values when unsigned). Magnitudes are WIDTH-bit unsigned, so |most-negative| = 2^(WIDTH-1).
  - If divisor==0, go to DONE directly. Otherwise clear A (WIDTH+1 bits), load Q=|dividend|, counter=WIDTH, and go to CALC.
- CALC, one restoring step per cycle:
  - {A,Q} <<= 1.
  - T = A - {0,|divisor|}.
  - If T is non-negative (T[WIDTH]==0): A=T, Q[0]=1. Else A is unchanged, Q[0]=0.
  - Decrement counter. When counter reaches 1 at this edge, go to FIX.
- FIX:
  - quotient = neg_q ? -Q : Q.
  - remainder = neg_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
  - div_by_zero=0. Go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - For divide-by-zero: quotient = all ones, remainder = original dividend (unmodified, either mode), div_by_zero=1.
  - Return to IDLE unconditionally. start during DONE is ignored.
- Latency, with start accepted at edge 0:
  - Normal divide: CALC occupies cycles 1..WIDTH, FIX is cycle WIDTH+1, done is high in cycle WIDTH+2. For WIDTH=32, done is high 34 cycles after acceptance.
  - Divide-by-zero: done is high in cycle 1.
- busy is high in CALC and FIX only.
- Back-to-back: a new start is accepted in the IDLE cycle following DONE. Minimum issue interval is WIDTH+3 cycles.
- start while busy or in DONE is ignored. It is neither queued nor errored. Operand inputs may change freely after acceptance.
- Outputs hold their last result until the next done. They are not cleared on start.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0 (natural wrap of the magnitude result). div_by_zero stays 0.
- Sign rules: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
- Reset mid-operation (any state): abort immediately with all outputs at reset values. No done pulse is issued for the aborted operation.
- reset has priority over start in the same cycle.

Decomposition:
- Shared package div_pkg:
  - typedef enum div_state_t {IDLE, CALC, FIX, DONE}.
  - Localparams for the state encoding.
  - Helper function abs_mag(value, is_signed) returning the unsigned magnitude.
- Sub-module div_step (combinational, parametrised on WIDTH):
  - Inputs: A, Q, |divisor|.
  - Outputs: next A, next Q.
  - Reusable later for an unrolled or radix-4 variant.

Test Plan:
- WIDTH=32, unsigned, 100/7 -> done exactly 34 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; busy high for cycles 1..33.
- WIDTH=32, signed, -100/7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100/-7 -> quotient=-14, remainder=2.
- Divisor 0, dividend 0x12345678, either mode -> done in cycle 1; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Assert start every cycle with changing operands during an operation -> only the first operation completes, with the first operands' result. Next start is accepted in the cycle after done.
- Assert reset at cycle 10 of a divide -> no done pulse; outputs are 0 next cycle. A new divide started after reset returns the correct result.
- WIDTH=8 build, unsigned 200/13 -> quotient=15, remainder=5, done in cycle 10.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned MAG_W   = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Caller sign-extends its operand to MAG_W and truncates the result back.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] value,
                                               input logic             is_signed);
    return (is_signed && value[MAG_W-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {A,Q} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] t;

  // A < d holds between steps, so the partial remainder's top bit only exists
  // transiently inside the shifted trial value.
  always_comb begin
    sh     = {a, q[WIDTH-1]};
    t      = sh - {1'b0, d};
    q_next = {q[WIDTH-2:0], ~t[WIDTH]};
    a_next = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
module seq_div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state, nxt;

  logic [WIDTH-1:0] a, q, dmag;
  logic [WIDTH-1:0] a_nx, q_nx;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .q      (q),
    .d      (dmag),
    .a_next (a_nx),
    .q_next (q_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = (divisor == '0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) nxt = FIX;
      end
      FIX: begin
        busy = 1'b1;
        nxt  = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a           <= '0;
      q           <= '0;
      dmag        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r <= is_signed & dividend[WIDTH-1];
          dmag  <= WIDTH'(abs_mag(MAG_W'($signed(divisor)), is_signed));
          // Divide-by-zero results are published on entry to DONE.
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            a   <= '0;
            q   <= WIDTH'(abs_mag(MAG_W'($signed(dividend)), is_signed));
            cnt <= CW'(WIDTH);
          end
        end
        CALC: begin
          a   <= a_nx;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          quotient    <= neg_q ? -q : q;
          remainder   <= neg_r ? -a : a;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: randomized and directed divides vs. an arithmetic model.
module tb_seq_div;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    q;
    logic [W-1:0]    r;
    logic            dbz;
    longint unsigned lat;
    longint unsigned acc;
  } exp_t;

  exp_t            exp_q[$];
  int              checks   = 0;
  int              failures = 0;
  longint unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division on 64-bit values (truncates toward zero,
  // remainder carries the dividend's sign); result wrapped back to W bits.
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, qq, rr;
    e.acc = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1;
      return e;
    end
    if (sgn) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
    else     begin sa = longint'(a);          sb = longint'(b);          end
    qq = sa / sb;
    rr = sa % sb;
    e.q   = qq[W-1:0];
    e.r   = rr[W-1:0];
    e.dbz = 1'b0;
    e.lat = W + 2;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done at cycle %0d (no operation outstanding)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient",    64'(quotient),    64'(e.q));
        check("remainder",   64'(remainder),   64'(e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("latency",     cyc - e.acc,      e.lat);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // IDLE cycle after done. hammer keeps start high with junk operands throughout.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hammer);
    exp_t        e;
    int unsigned nbusy = 0;
    bit          seen  = 0;
    e     = model(sgn, a, b);
    e.acc = cyc;
    exp_q.push_back(e);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (hammer) begin
        start = 1'b1; is_signed = 1'($urandom_range(0, 1));
        dividend = $urandom; divisor = W'($urandom_range(0, 50));
      end else begin
        start = 1'b0;
      end
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_200_cycles");
      void'(exp_q.pop_front());
    end
    check("busy_cycles", 64'(nbusy), (b == '0) ? 64'd0 : 64'(W + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned  sel;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  64'(busy),        64'd0);
    check("reset_done",  64'(done),        64'd0);
    check("reset_q",     64'(quotient),    64'd0);
    check("reset_r",     64'(remainder),   64'd0);
    check("reset_dbz",   64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd100, 32'd7, 1'b0);
    issue(1'b1, -32'sd100, 32'd7, 1'b0);
    issue(1'b1, 32'd100, -32'sd7, 1'b0);
    issue(1'b0, 32'h1234_5678, 32'd0, 1'b0);
    issue(1'b1, 32'h1234_5678, 32'd0, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    issue(1'b1, 32'd77, 32'd0, 1'b1);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Abort a divide mid-flight; nothing is pushed, so any done is unexpected.
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy),        64'd0);
    check("abort_done", 64'(done),        64'd0);
    check("abort_q",    64'(quotient),    64'd0);
    check("abort_r",    64'(remainder),   64'd0);
    check("abort_dbz",  64'(div_by_zero), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0)      rb = '0;
      else if (sel < 4)  rb = W'($urandom_range(1, 300));
      else if (sel == 4) begin ra = 32'h8000_0000; rb = '1; end
      else if (sel == 5) rb = rb >> $urandom_range(0, 31);
      issue(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
